// File: rtl/battle_frame_sequencer.sv
// battle_frame_sequencer
//   Runs one battle frame per gameSCEN tick: front scan (BattleFront
//   Start/Done/Ack handshake), then damage, then movement. The scan results
//   stay latched for the damage and movement units until the next scan
//   completes. A tick that arrives while a frame is running is kept in a
//   one-deep pending slot; further ticks are counted as overruns. A phase
//   that waits TIMEOUT cycles parks the sequencer in a sticky FAULT state.
//
// Parameters
//   TIMEOUT           cycles allowed in any one waiting phase (1..65535)
//   FRAME_COUNT_INIT  reset value of frameCount (normally 0)
//   OVERRUN_INIT      reset value of overrunCount (normally 0)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   gameSCEN, run            frame tick and run enable (run=0 drops ticks)
//   frontDone                BattleFront Done (level)
//   friendlyFrontIn, enemyFrontIn, unitSelIn, enemySelIn   BattleFront results
//   damageDone, moveDone     completion from the damage / movement units
//   frontStart, frontAck     BattleFront Start (level) and Ack (1 cycle)
//   damageStart, moveStart   1-cycle start pulses
//   friendlyFront, enemyFront, unitDamageSelect, enemyDamageSelect  latched results
//   busy                     frame in progress (not IDLE, not FAULT)
//   frameDone                1-cycle pulse as a frame completes
//   frameCount               completed frames, wraps
//   overrunCount             dropped ticks, saturates at 255
//   fault                    sticky phase-timeout flag
module battle_frame_sequencer #(
  parameter int unsigned TIMEOUT          = 255,
  parameter logic [15:0] FRAME_COUNT_INIT = 16'd0,
  parameter logic [7:0]  OVERRUN_INIT     = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gameSCEN,
  input  logic        run,
  input  logic        frontDone,
  input  logic [8:0]  friendlyFrontIn,
  input  logic [8:0]  enemyFrontIn,
  input  logic [4:0]  unitSelIn,
  input  logic [4:0]  enemySelIn,
  input  logic        damageDone,
  input  logic        moveDone,
  output logic        frontStart,
  output logic        frontAck,
  output logic        damageStart,
  output logic        moveStart,
  output logic [8:0]  friendlyFront,
  output logic [8:0]  enemyFront,
  output logic [4:0]  unitDamageSelect,
  output logic [4:0]  enemyDamageSelect,
  output logic        busy,
  output logic        frameDone,
  output logic [15:0] frameCount,
  output logic [7:0]  overrunCount,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE, SCAN, DMG_GO, DMG_WAIT, MOV_GO, MOV_WAIT, FIN, FAULT
  } state_t;

  // The phase times out on the cycle whose increment would make the counter
  // reach TIMEOUT, so a phase lasts at most TIMEOUT cycles.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        pending;
  logic [15:0] phase_cnt;

  logic tick;
  logic waiting;
  logic timeout_hit;
  logic overrun_inc;

  assign tick        = gameSCEN & run;
  assign waiting     = (state == SCAN) || (state == DMG_WAIT) || (state == MOV_WAIT);
  assign timeout_hit = waiting && (phase_cnt == TIMEOUT_LAST);

  // Ack must answer Done in the same cycle, so the handshake outputs are
  // decoded from the state register and frontDone. A timeout in the same
  // cycle wins, so no Ack is given then.
  assign frontAck   = (state == SCAN) && frontDone && !timeout_hit;
  assign frontStart = (state == SCAN) && !frontAck;

  // A live tick becomes an overrun whenever the pending slot is already full,
  // both mid-frame and in IDLE (where the pending frame is launched instead).
  assign overrun_inc = tick && (state != FAULT) && pending;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // read below sees the value from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      pending           <= 1'b0;
      phase_cnt         <= 16'd0;
      damageStart       <= 1'b0;
      moveStart         <= 1'b0;
      busy              <= 1'b0;
      frameDone         <= 1'b0;
      fault             <= 1'b0;
      frameCount        <= FRAME_COUNT_INIT;
      overrunCount      <= OVERRUN_INIT;
      friendlyFront     <= 9'h1FF;
      enemyFront        <= 9'd0;
      unitDamageSelect  <= 5'b10000;
      enemyDamageSelect <= 5'b10000;
    end else begin
      // Strobes default low; the transitions below raise them for one cycle.
      damageStart <= 1'b0;
      moveStart   <= 1'b0;
      frameDone   <= 1'b0;

      if (overrun_inc && (overrunCount != 8'hFF)) begin
        overrunCount <= overrunCount + 8'd1;
      end

      // IDLE always launches a frame when pending is set, so it can clear it.
      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (tick && (state != FAULT)) begin
        pending <= 1'b1;
      end

      // Counts while waiting; transitions out of a waiting state clear it.
      phase_cnt <= waiting ? phase_cnt + 16'd1 : 16'd0;

      case (state)
        IDLE: begin
          if (tick || pending) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (timeout_hit) begin
            state     <= FAULT;
            fault     <= 1'b1;
            busy      <= 1'b0;
            phase_cnt <= 16'd0;
          end else if (frontDone) begin
            friendlyFront     <= friendlyFrontIn;
            enemyFront        <= enemyFrontIn;
            unitDamageSelect  <= unitSelIn;
            enemyDamageSelect <= enemySelIn;
            damageStart       <= 1'b1;
            state             <= DMG_GO;
            phase_cnt         <= 16'd0;
          end
        end
        DMG_GO: state <= DMG_WAIT;
        DMG_WAIT: begin
          if (timeout_hit) begin
            state     <= FAULT;
            fault     <= 1'b1;
            busy      <= 1'b0;
            phase_cnt <= 16'd0;
          end else if (damageDone) begin
            moveStart <= 1'b1;
            state     <= MOV_GO;
            phase_cnt <= 16'd0;
          end
        end
        MOV_GO: state <= MOV_WAIT;
        MOV_WAIT: begin
          if (timeout_hit) begin
            state     <= FAULT;
            fault     <= 1'b1;
            busy      <= 1'b0;
            phase_cnt <= 16'd0;
          end else if (moveDone) begin
            frameDone <= 1'b1;
            state     <= FIN;
            phase_cnt <= 16'd0;
          end
        end
        FIN: begin
          frameCount <= frameCount + 16'd1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        FAULT: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_battle_frame_sequencer.sv
// Directed testbench for battle_frame_sequencer. Cycle c of each scenario
// starts at a rising edge; inputs are driven 1 time unit after it and
// outputs are sampled on the following falling edge. A second instance
// with preloaded counters covers frameCount wrap and overrun saturation.
module tb_battle_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gameSCEN, run, frontDone, damageDone, moveDone;
  logic [8:0]  friendlyFrontIn, enemyFrontIn;
  logic [4:0]  unitSelIn, enemySelIn;

  logic        frontStart, frontAck, damageStart, moveStart, busy, frameDone, fault;
  logic [8:0]  friendlyFront, enemyFront;
  logic [4:0]  unitDamageSelect, enemyDamageSelect;
  logic [15:0] frameCount;
  logic [7:0]  overrunCount;

  logic        p_frontStart, p_frontAck, p_damageStart, p_moveStart, p_busy, p_frameDone, p_fault;
  logic [8:0]  p_friendlyFront, p_enemyFront;
  logic [4:0]  p_unitDamageSelect, p_enemyDamageSelect;
  logic [15:0] p_frameCount;
  logic [7:0]  p_overrunCount;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  battle_frame_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .gameSCEN(gameSCEN), .run(run), .frontDone(frontDone),
    .friendlyFrontIn(friendlyFrontIn), .enemyFrontIn(enemyFrontIn),
    .unitSelIn(unitSelIn), .enemySelIn(enemySelIn),
    .damageDone(damageDone), .moveDone(moveDone),
    .frontStart(frontStart), .frontAck(frontAck),
    .damageStart(damageStart), .moveStart(moveStart),
    .friendlyFront(friendlyFront), .enemyFront(enemyFront),
    .unitDamageSelect(unitDamageSelect), .enemyDamageSelect(enemyDamageSelect),
    .busy(busy), .frameDone(frameDone), .frameCount(frameCount),
    .overrunCount(overrunCount), .fault(fault)
  );

  battle_frame_sequencer #(.TIMEOUT(8), .FRAME_COUNT_INIT(16'hFFFF), .OVERRUN_INIT(8'hFF)) dut_pre (
    .clk(clk), .rst(rst), .gameSCEN(gameSCEN), .run(run), .frontDone(frontDone),
    .friendlyFrontIn(friendlyFrontIn), .enemyFrontIn(enemyFrontIn),
    .unitSelIn(unitSelIn), .enemySelIn(enemySelIn),
    .damageDone(damageDone), .moveDone(moveDone),
    .frontStart(p_frontStart), .frontAck(p_frontAck),
    .damageStart(p_damageStart), .moveStart(p_moveStart),
    .friendlyFront(p_friendlyFront), .enemyFront(p_enemyFront),
    .unitDamageSelect(p_unitDamageSelect), .enemyDamageSelect(p_enemyDamageSelect),
    .busy(p_busy), .frameDone(p_frameDone), .frameCount(p_frameCount),
    .overrunCount(p_overrunCount), .fault(p_fault)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Idle inputs; the front/select inputs carry values that must never be
  // latched unless frontDone is high.
  task automatic drive_defaults();
    gameSCEN        = 1'b0;
    run             = 1'b1;
    frontDone       = 1'b0;
    friendlyFrontIn = 9'd300;
    enemyFrontIn    = 9'd301;
    unitSelIn       = 5'd21;
    enemySelIn      = 5'd22;
    damageDone      = 1'b0;
    moveDone        = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    drive_defaults();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (frontStart !== 1'b0) $display("FAIL reset.frontStart got=%b exp=0", frontStart); else passed++;
    total++; if (frontAck !== 1'b0) $display("FAIL reset.frontAck got=%b exp=0", frontAck); else passed++;
    total++; if (damageStart !== 1'b0) $display("FAIL reset.damageStart got=%b exp=0", damageStart); else passed++;
    total++; if (moveStart !== 1'b0) $display("FAIL reset.moveStart got=%b exp=0", moveStart); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset.busy got=%b exp=0", busy); else passed++;
    total++; if (frameDone !== 1'b0) $display("FAIL reset.frameDone got=%b exp=0", frameDone); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL reset.fault got=%b exp=0", fault); else passed++;
    total++; if (friendlyFront !== 9'h1FF) $display("FAIL reset.friendlyFront got=%h exp=1ff", friendlyFront); else passed++;
    total++; if (enemyFront !== 9'h000) $display("FAIL reset.enemyFront got=%h exp=000", enemyFront); else passed++;
    total++; if (unitDamageSelect !== 5'd16) $display("FAIL reset.unitDamageSelect got=%0d exp=16", unitDamageSelect); else passed++;
    total++; if (enemyDamageSelect !== 5'd16) $display("FAIL reset.enemyDamageSelect got=%0d exp=16", enemyDamageSelect); else passed++;
    total++; if (frameCount !== 16'd0) $display("FAIL reset.frameCount got=%0d exp=0", frameCount); else passed++;
    total++; if (overrunCount !== 8'd0) $display("FAIL reset.overrunCount got=%0d exp=0", overrunCount); else passed++;
    total++; if (p_frameCount !== 16'hFFFF) $display("FAIL reset.preFrameCount got=%h exp=ffff", p_frameCount); else passed++;
  endtask

  task automatic test_single_frame();
    do_reset();
    for (int c = 0; c <= 23; c++) begin
      next_cycle();
      drive_defaults();
      gameSCEN = (c == 10);
      if (c == 14) begin
        frontDone       = 1'b1;
        friendlyFrontIn = 9'd120;
        enemyFrontIn    = 9'd40;
        unitSelIn       = 5'd3;
        enemySelIn      = 5'd7;
      end
      damageDone = (c == 17);
      moveDone   = (c == 20);
      @(negedge clk);
      total++; if (frontStart !== (c >= 11 && c <= 13)) $display("FAIL single.frontStart c=%0d got=%b", c, frontStart); else passed++;
      total++; if (frontAck !== (c == 14)) $display("FAIL single.frontAck c=%0d got=%b", c, frontAck); else passed++;
      total++; if (damageStart !== (c == 15)) $display("FAIL single.damageStart c=%0d got=%b", c, damageStart); else passed++;
      total++; if (moveStart !== (c == 18)) $display("FAIL single.moveStart c=%0d got=%b", c, moveStart); else passed++;
      total++; if (frameDone !== (c == 21)) $display("FAIL single.frameDone c=%0d got=%b", c, frameDone); else passed++;
      total++; if (busy !== (c >= 11 && c <= 21)) $display("FAIL single.busy c=%0d got=%b", c, busy); else passed++;
      if (c == 14) begin
        total++; if (friendlyFront !== 9'h1FF) $display("FAIL single.earlyLatch got=%0d exp=511", friendlyFront); else passed++;
      end
    end
    total++; if (frameCount !== 16'd1) $display("FAIL single.frameCount got=%0d exp=1", frameCount); else passed++;
    total++; if (friendlyFront !== 9'd120) $display("FAIL single.friendlyFront got=%0d exp=120", friendlyFront); else passed++;
    total++; if (enemyFront !== 9'd40) $display("FAIL single.enemyFront got=%0d exp=40", enemyFront); else passed++;
    total++; if (unitDamageSelect !== 5'd3) $display("FAIL single.unitDamageSelect got=%0d exp=3", unitDamageSelect); else passed++;
    total++; if (enemyDamageSelect !== 5'd7) $display("FAIL single.enemyDamageSelect got=%0d exp=7", enemyDamageSelect); else passed++;
    total++; if (overrunCount !== 8'd0) $display("FAIL single.overrunCount got=%0d exp=0", overrunCount); else passed++;
  endtask

  task automatic test_pause();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      next_cycle();
      drive_defaults();
      run      = (c == 10);
      gameSCEN = (c < 10) && (c % 2 == 0);
      @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL pause.busy c=%0d got=%b exp=0", c, busy); else passed++;
      total++; if (frontStart !== 1'b0) $display("FAIL pause.frontStart c=%0d got=%b exp=0", c, frontStart); else passed++;
    end
    total++; if (overrunCount !== 8'd0) $display("FAIL pause.overrunCount got=%0d exp=0", overrunCount); else passed++;
    total++; if (frameCount !== 16'd0) $display("FAIL pause.frameCount got=%0d exp=0", frameCount); else passed++;
  endtask

  // Frame 1: ticks at 3 (pending), 5 and 7 (overruns). The tick at 9 lands
  // in IDLE with pending set: it launches frame 2 and is itself an overrun.
  task automatic test_overrun();
    int exp_ovr;
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      next_cycle();
      drive_defaults();
      gameSCEN   = (c inside {0, 3, 5, 7, 9});
      frontDone  = (c == 3) || (c == 11);
      damageDone = (c == 5) || (c == 13);
      moveDone   = (c == 7) || (c == 15);
      @(negedge clk);
      exp_ovr = (c >= 10) ? 3 : (c >= 8) ? 2 : (c >= 6) ? 1 : 0;
      total++; if (overrunCount !== 8'(exp_ovr)) $display("FAIL overrun.count c=%0d got=%0d exp=%0d", c, overrunCount, exp_ovr); else passed++;
      total++; if (frontStart !== (c inside {1, 2, 10})) $display("FAIL overrun.frontStart c=%0d got=%b", c, frontStart); else passed++;
      total++; if (frameDone !== (c == 8 || c == 16)) $display("FAIL overrun.frameDone c=%0d got=%b", c, frameDone); else passed++;
      total++; if (busy !== ((c >= 1 && c <= 8) || (c >= 10 && c <= 16))) $display("FAIL overrun.busy c=%0d got=%b", c, busy); else passed++;
    end
    total++; if (frameCount !== 16'd2) $display("FAIL overrun.frameCount got=%0d exp=2", frameCount); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      next_cycle();
      drive_defaults();
      gameSCEN   = (c inside {0, 3, 4, 6});
      frontDone  = (c == 1);
      damageDone = (c == 3);
      moveDone   = (c == 5);
      @(negedge clk);
      if (c == 6) begin
        total++; if (p_frameDone !== 1'b1) $display("FAIL wrap.frameDone got=%b exp=1", p_frameDone); else passed++;
        total++; if (p_frameCount !== 16'hFFFF) $display("FAIL wrap.beforeWrap got=%h exp=ffff", p_frameCount); else passed++;
      end
      if (c == 7) begin
        total++; if (p_frameCount !== 16'd0) $display("FAIL wrap.frameCount got=%h exp=0000", p_frameCount); else passed++;
        total++; if (p_overrunCount !== 8'd255) $display("FAIL wrap.saturate got=%0d exp=255", p_overrunCount); else passed++;
        total++; if (overrunCount !== 8'd2) $display("FAIL wrap.finTick got=%0d exp=2", overrunCount); else passed++;
        total++; if (frameCount !== 16'd1) $display("FAIL wrap.plainCount got=%0d exp=1", frameCount); else passed++;
      end
      if (c == 8) begin
        total++; if (p_frontStart !== 1'b1) $display("FAIL wrap.pendingStart got=%b exp=1", p_frontStart); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      next_cycle();
      drive_defaults();
      gameSCEN = (c inside {0, 2, 3});
      if (c == 1) begin
        frontDone       = 1'b1;
        friendlyFrontIn = 9'd77;
        enemyFrontIn    = 9'd200;
        unitSelIn       = 5'd5;
        enemySelIn      = 5'd9;
      end
      damageDone = (c == 3);
      moveDone   = (c == 5);
      rst        = (c == 8);
      @(negedge clk);
      if (c == 8) begin
        total++; if (frontStart !== 1'b1) $display("FAIL rstscan.inScan got=%b exp=1", frontStart); else passed++;
        total++; if (friendlyFront !== 9'd77) $display("FAIL rstscan.latched got=%0d exp=77", friendlyFront); else passed++;
        total++; if (overrunCount !== 8'd1) $display("FAIL rstscan.preOverrun got=%0d exp=1", overrunCount); else passed++;
      end
      if (c == 9) begin
        total++; if (frontStart !== 1'b0) $display("FAIL rstscan.frontStart got=%b exp=0", frontStart); else passed++;
        total++; if (friendlyFront !== 9'h1FF) $display("FAIL rstscan.friendlyFront got=%h exp=1ff", friendlyFront); else passed++;
        total++; if (enemyFront !== 9'd0) $display("FAIL rstscan.enemyFront got=%0d exp=0", enemyFront); else passed++;
        total++; if (unitDamageSelect !== 5'd16) $display("FAIL rstscan.unitSel got=%0d exp=16", unitDamageSelect); else passed++;
        total++; if (enemyDamageSelect !== 5'd16) $display("FAIL rstscan.enemySel got=%0d exp=16", enemyDamageSelect); else passed++;
        total++; if (frameCount !== 16'd0) $display("FAIL rstscan.frameCount got=%0d exp=0", frameCount); else passed++;
        total++; if (overrunCount !== 8'd0) $display("FAIL rstscan.overrunCount got=%0d exp=0", overrunCount); else passed++;
      end
      if (c == 10) begin
        total++; if (busy !== 1'b0) $display("FAIL rstscan.pendingCleared got=%b exp=0", busy); else passed++;
      end
    end
  endtask

  // TIMEOUT=8: DMG_WAIT is entered at cycle 3, so FAULT appears at 11. The
  // damageDone at 10 coincides with the timeout and must lose.
  task automatic test_timeout();
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      next_cycle();
      drive_defaults();
      gameSCEN   = (c == 0) || (c >= 12 && c <= 16);
      frontDone  = (c == 1);
      damageDone = (c == 10);
      @(negedge clk);
      total++; if (frontAck !== (c == 1)) $display("FAIL timeout.frontAck c=%0d got=%b", c, frontAck); else passed++;
      total++; if (damageStart !== (c == 2)) $display("FAIL timeout.damageStart c=%0d got=%b", c, damageStart); else passed++;
      total++; if (fault !== (c >= 11)) $display("FAIL timeout.fault c=%0d got=%b", c, fault); else passed++;
      total++; if (busy !== (c >= 1 && c <= 10)) $display("FAIL timeout.busy c=%0d got=%b", c, busy); else passed++;
      total++; if (moveStart !== 1'b0) $display("FAIL timeout.moveStart c=%0d got=%b exp=0", c, moveStart); else passed++;
      total++; if (frontStart !== 1'b0) $display("FAIL timeout.frontStart c=%0d got=%b exp=0", c, frontStart); else passed++;
      total++; if (overrunCount !== 8'd0) $display("FAIL timeout.overrunCount c=%0d got=%0d exp=0", c, overrunCount); else passed++;
    end
    next_cycle();
    drive_defaults();
    rst = 1'b1;
    next_cycle();
    rst      = 1'b0;
    gameSCEN = 1'b1;
    @(negedge clk);
    total++; if (fault !== 1'b0) $display("FAIL timeout.clearedFault got=%b exp=0", fault); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL timeout.clearedBusy got=%b exp=0", busy); else passed++;
    next_cycle();
    gameSCEN = 1'b0;
    @(negedge clk);
    total++; if (frontStart !== 1'b1) $display("FAIL timeout.restart got=%b exp=1", frontStart); else passed++;
  endtask

  initial begin
    drive_defaults();
    test_reset();
    test_single_frame();
    test_pause();
    test_overrun();
    test_wrap();
    test_reset_mid_scan();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/battle_frame_sequencer.md
# battle_frame_sequencer

Frame-level controller that sequences one game frame of the battle datapath per `gameSCEN` tick. It runs three phases in order: front scan, damage, then movement. The front scan uses the BattleFront Start/Done/Ack handshake; the front positions and damage selects are latched for the downstream damage and movement units. It sits between the frame-tick generator and the battle units, and it tracks frame count, tick overruns and a stalled-phase fault.

## Interface
- TIMEOUT, 255: max cycles spent waiting in any one phase before fault (1..65535)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- gameSCEN  in  1  one-cycle frame tick
- run  in  1  1 = accept ticks, 0 = paused (ticks dropped, not counted)
- frontDone  in  1  BattleFront Done (level)
- friendlyFrontIn, enemyFrontIn  in  9  BattleFront fronts
- unitSelIn, enemySelIn  in  5  BattleFront damage selects
- damageDone  in  1  damage unit done (1-cycle pulse or level)
- moveDone  in  1  movement unit done (1-cycle pulse or level)
- frontStart  out  1  level Start to BattleFront
- frontAck  out  1  1-cycle Ack to BattleFront
- damageStart, moveStart  out  1  1-cycle start pulses
- friendlyFront, enemyFront  out  9  latched fronts
- unitDamageSelect, enemyDamageSelect  out  5  latched selects
- busy  out  1  high in any state except IDLE and FAULT
- frameDone  out  1  1-cycle pulse on frame completion
- frameCount  out  16  completed frames, wraps 0xFFFF→0
- overrunCount  out  8  dropped ticks, saturates at 255
- fault  out  1  sticky, phase timeout

## Operation
- States: IDLE, SCAN, DMG_GO, DMG_WAIT, MOV_GO, MOV_WAIT, FIN, FAULT.
- IDLE
  - If (gameSCEN & run) or `pending` is set, go to SCAN and clear `pending`.
- SCAN
  - `frontStart` = 1.
  - When `frontDone` is 1, latch all four BattleFront outputs, pulse `frontAck` in the same cycle, and go to DMG_GO.
  - `frontStart` is 0 in that Ack cycle and in every state after it.
- DMG_GO
  - `damageStart` = 1 for one cycle, then go to DMG_WAIT.
- DMG_WAIT
  - On `damageDone`, go to MOV_GO.
- MOV_GO / MOV_WAIT
  - Same pattern as DMG_GO / DMG_WAIT, using `moveStart` and `moveDone`.
  - On `moveDone`, go to FIN.
- FIN
  - `frameDone` = 1, `frameCount`++, then go to IDLE.
- Timeout
  - A 16-bit phase counter clears on every state change and increments while in SCAN, DMG_WAIT or MOV_WAIT.
  - When it reaches TIMEOUT, go to FAULT and set `fault`.
  - FAULT holds all strobes low and is left only by `rst`.
- Overrun
  - Applies to gameSCEN & run while the state is not IDLE.
  - If `pending` is 0, set `pending`; otherwise increment `overrunCount` (saturating).
  - A tick in IDLE with `pending` already set starts the frame, clears `pending` and increments `overrunCount`.
  - Ticks in FAULT are ignored.
- Latched fronts and selects hold their value until the next SCAN completes.

## Timing
- Reset values: state IDLE.
  - Strobes, `busy`, `fault`, `pending`: 0.
  - `frameCount`, `overrunCount`: 0.
  - `friendlyFront` = 9'h1FF, `enemyFront` = 0.
  - Selects = 5'b10000 (tower).
- Tick to `frontStart`: 1 cycle. Tick sampled in IDLE at cycle N gives SCAN at N+1.
- `frontDone` seen at cycle M: `frontAck` is asserted in cycle M and `damageStart` in cycle M+1.
- Done to next start: 1 cycle. `moveDone` at cycle K gives `frameDone` at K+1 and IDLE at K+2.
- Minimum frame length: SCAN(≥1) + 1 + DMG_WAIT(≥1) + 1 + MOV_WAIT(≥1) + 1 = 6 cycles.
- A done input that is already high on entry to a WAIT state is accepted in that first WAIT cycle.
- A tick arriving in the FIN cycle sets `pending`. The next frame starts at IDLE+1, i.e. SCAN 2 cycles after FIN.
- Timeout takes precedence over a done input arriving in the same cycle.
- `rst` mid-frame returns to IDLE next cycle with every reset value applied. BattleFront is expected to be reset by the same `rst`.

## Test plan
- Single frame:
  - Stimulus: gameSCEN at cycle 10; frontDone at cycle 14 with fronts 9'd120 / 9'd40 and selects 3 / 7; damageDone at 17; moveDone at 20.
  - Required: `frontAck` at 14, `damageStart` at 15, `moveStart` at 18, `frameDone` at 21, `frameCount` = 1, outputs latched = 120 / 40 / 3 / 7.
- Overrun:
  - Stimulus: three ticks during one frame.
  - Required: `pending` set by the first; `overrunCount` = 2; the second frame starts 2 cycles after the first `frameDone`.
- Pause:
  - Stimulus: run = 0 with 5 ticks.
  - Required: state stays IDLE, `overrunCount` = 0, `frameCount` = 0.
- Timeout:
  - Stimulus: TIMEOUT = 8, damageDone never arrives.
  - Required: FAULT 8 cycles after entering DMG_WAIT, `fault` = 1, `busy` = 0; later ticks ignored until `rst`.
- Reset mid-SCAN:
  - Stimulus: assert `rst` while `frontStart` = 1.
  - Required: next cycle `frontStart` = 0, fronts 9'h1FF / 0, selects 16, counters 0.
- Wrap and saturation:
  - Stimulus: preload to frameCount 0xFFFF and overrunCount 255 (or run long); complete one frame with extra overrun ticks.
  - Required: `frameCount` = 0 and `overrunCount` stays 255.
